// File: rtl/sysid_check_ctrl_pkg.sv
// Shared definitions for the system-ID self-check controller: FSM states,
// sysid word addresses, counter width and the saturating increment.
package sysid_check_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_ID   = 3'd1,
      S_WAIT_ID = 3'd2,
      S_RD_TS   = 3'd3,
      S_WAIT_TS = 3'd4,
      S_EVAL    = 3'd5
   } state_t;

   localparam logic        ADDR_ID = 1'b0;
   localparam logic        ADDR_TS = 1'b1;
   localparam int unsigned CNT_W   = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/sysid_check_ctrl_timer.sv
// Free-running recheck timer: pulses tick on the PERIOD-th enabled cycle
// since the last clear; holds while disabled, clear has priority.
module sysid_period_timer #(
   parameter int unsigned PERIOD = 50000000
)(
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int unsigned    CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0]  LAST = CW'(PERIOD - 1);

   logic [CW-1:0] r_count;
   logic          w_last;

   assign w_last = (r_count == LAST);
   assign tick   = enable && w_last;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= w_last ? '0 : r_count + CW'(1);
      end
   end

endmodule

// File: rtl/sysid_check_ctrl.sv
// Avalon-MM read master that fetches sysid words 0 and 1, compares them with
// the expected ID/timestamp and keeps saturating check/fail counters.
module sysid_check_ctrl
   import sysid_check_ctrl_pkg::*;
#(
   parameter logic [31:0] EXP_ID       = 32'd0,
   parameter logic [31:0] EXP_TS       = 32'd1375083247,
   parameter int unsigned READ_LATENCY = 0,
   parameter int unsigned PERIOD       = 50000000
)(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              auto_en,
   output logic              sid_address,
   output logic              sid_read,
   input  logic [31:0]       sid_readdata,
   output logic              busy,
   output logic              done,
   output logic              id_ok,
   output logic              ts_ok,
   output logic              pass,
   output logic [31:0]       id_value,
   output logic [31:0]       ts_value,
   output logic [CNT_W-1:0]  check_count,
   output logic [CNT_W-1:0]  fail_count
);

   localparam logic [1:0] LAT = 2'(READ_LATENCY);

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_lat;
   logic             w_tick;
   logic             w_launch;
   logic             w_rd;
   logic             w_addr;
   logic             w_cap_id;
   logic             w_cap_ts;
   logic             w_id_ok;
   logic             w_ts_ok;
   logic             r_done;
   logic             r_id_ok;
   logic             r_ts_ok;
   logic             r_pass;
   logic [31:0]      r_id_value;
   logic [31:0]      r_ts_value;
   logic [CNT_W-1:0] r_check_count;
   logic [CNT_W-1:0] r_fail_count;

   assign w_launch = (r_state == S_IDLE) && (start || w_tick);
   assign w_id_ok  = (r_id_value == EXP_ID);
   assign w_ts_ok  = (r_ts_value == EXP_TS);

   sysid_period_timer #(
      .PERIOD (PERIOD)
   ) u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (auto_en && (r_state == S_IDLE)),
      .clear   (w_launch || !auto_en),
      .tick    (w_tick)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_rd     = 1'b0;
      w_addr   = ADDR_ID;
      w_cap_id = 1'b0;
      w_cap_ts = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start || w_tick) w_next = S_RD_ID;
         end
         S_RD_ID: begin
            w_rd = 1'b1;
            if (READ_LATENCY == 0) begin
               w_cap_id = 1'b1;
               w_next   = S_RD_TS;
            end else begin
               w_next   = S_WAIT_ID;
            end
         end
         S_WAIT_ID: begin
            if (r_lat == LAT) begin
               w_cap_id = 1'b1;
               w_next   = S_RD_TS;
            end
         end
         S_RD_TS: begin
            w_rd   = 1'b1;
            w_addr = ADDR_TS;
            if (READ_LATENCY == 0) begin
               w_cap_ts = 1'b1;
               w_next   = S_EVAL;
            end else begin
               w_next   = S_WAIT_TS;
            end
         end
         S_WAIT_TS: begin
            w_addr = ADDR_TS;
            if (r_lat == LAT) begin
               w_cap_ts = 1'b1;
               w_next   = S_EVAL;
            end
         end
         S_EVAL:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // r_lat numbers the wait cycles 1..READ_LATENCY; the read cycle itself is 0
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_lat <= '0;
      end else begin
         case (r_state)
            S_RD_ID, S_RD_TS:     r_lat <= 2'd1;
            S_WAIT_ID, S_WAIT_TS: r_lat <= r_lat + 2'd1;
            default:              r_lat <= '0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_done        <= 1'b0;
         r_id_ok       <= 1'b0;
         r_ts_ok       <= 1'b0;
         r_pass        <= 1'b0;
         r_id_value    <= '0;
         r_ts_value    <= '0;
         r_check_count <= '0;
         r_fail_count  <= '0;
      end else begin
         r_done <= (r_state == S_EVAL);
         if (w_cap_id) r_id_value <= sid_readdata;
         if (w_cap_ts) r_ts_value <= sid_readdata;
         if (r_state == S_EVAL) begin
            r_id_ok       <= w_id_ok;
            r_ts_ok       <= w_ts_ok;
            r_pass        <= w_id_ok && w_ts_ok;
            r_check_count <= sat_inc(r_check_count);
            if (!(w_id_ok && w_ts_ok)) r_fail_count <= sat_inc(r_fail_count);
         end
      end
   end

   assign sid_read    = w_rd;
   assign sid_address = w_addr;
   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;
   assign id_ok       = r_id_ok;
   assign ts_ok       = r_ts_ok;
   assign pass        = r_pass;
   assign id_value    = r_id_value;
   assign ts_value    = r_ts_value;
   assign check_count = r_check_count;
   assign fail_count  = r_fail_count;

endmodule
